snowv_fsm_update: RTL and testbench

Holds the three 128-bit SNOW-V FSM registers R1/R2/R3, produces the 128-bit keystream word z, and performs the FSM update. The AES round work is delegated to two external AES encryption-round units (zero round key) through their start/ready handshake, and the results are committed atomically. Sits between the LFSR stage, which supplies T1/T2, and the keystream output logic.

---
 rtl/snowv_fsm_update.sv | 132 +++++++++++++
 tb/tb_snowv_fsm_update.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snowv_fsm_update.sv
// rtl/snowv_fsm_update.sv - SNOW-V FSM R1/R2/R3, keystream z, AES-delegated update
// Optional SNOWV_FSM_ZREG_EN registers z (one-cycle lag, reset 0); default is combinational z.
module snowv_fsm_update (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [127:0] r1_i,
    input  logic [127:0] r2_i,
    input  logic [127:0] r3_i,
    input  logic         start,
    input  logic [127:0] t1,
    input  logic [127:0] t2,
    output logic         aes1_start,
    output logic         aes2_start,
    output logic [127:0] aes1_block_i,
    output logic [127:0] aes2_block_i,
    input  logic [127:0] aes1_block_o,
    input  logic [127:0] aes2_block_o,
    input  logic         aes1_ready,
    input  logic         aes2_ready,
    output logic [127:0] z,
    output logic         ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] r1_q, r1_d;
    logic [127:0] r2_q, r2_d;
    logic [127:0] r3_q, r3_d;
    logic [127:0] t2_q, t2_d;
    logic         aes_start_c;
    logic [127:0] z_c;

    // Four independent 32-bit adds; carries never cross lane boundaries.
    function automatic logic [127:0] add32x4(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] s;
        for (int l = 0; l < 4; l++) begin
            s[32*l +: 32] = a[32*l +: 32] + b[32*l +: 32];
        end
        return s;
    endfunction

    // Output byte i takes input byte 4*(i mod 4) + i/4 (a 4x4 byte transpose).
    function automatic logic [127:0] sigma(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) begin
            y[8*i +: 8] = x[8*(4*(i % 4) + i / 4) +: 8];
        end
        return y;
    endfunction

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        t2_d        = t2_q;
        aes_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    r1_d = r1_i;
                    r2_d = r2_i;
                    r3_d = r3_i;
                end else if (start) begin
                    t2_d    = t2;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                aes_start_c = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // All three registers commit together in the same cycle.
                if (aes1_ready && aes2_ready) begin
                    r1_d    = sigma(add32x4(r2_q, r3_q ^ t2_q));
                    r2_d    = aes1_block_o;
                    r3_d    = aes2_block_o;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            t2_q    <= '0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            t2_q    <= t2_d;
        end
    end

    assign z_c = add32x4(r1_q, t1) ^ r2_q;

`ifdef SNOWV_FSM_ZREG_EN
    logic [127:0] z_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_q <= '0;
        end else begin
            z_q <= z_c;
        end
    end

    assign z = z_q;
`else
    assign z = z_c;
`endif

    assign aes1_start   = aes_start_c;
    assign aes2_start   = aes_start_c;
    assign aes1_block_i = r1_q;
    assign aes2_block_i = r2_q;
    assign ready        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_snowv_fsm_update.sv
// tb/tb_snowv_fsm_update.sv - directed self-checking bench for snowv_fsm_update
module tb_snowv_fsm_update;

    logic         clk;
    logic         reset_n;
    logic         load;
    logic [127:0] r1_i, r2_i, r3_i;
    logic         start;
    logic [127:0] t1, t2;
    logic         aes1_start, aes2_start;
    logic [127:0] aes1_block_i, aes2_block_i;
    logic [127:0] aes1_block_o, aes2_block_o;
    logic         aes1_ready, aes2_ready;
    logic [127:0] z;
    logic         ready;

    int total = 0;
    int bad   = 0;

    logic [127:0] aes1_val, aes2_val;
    int           ex1, ex2;
    int           c1, c2;

    localparam logic [127:0] ALL63  = {16{8'h63}};
    localparam logic [127:0] ALLC6  = {16{8'hC6}};
    localparam logic [127:0] SEQ    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SIGSEQ = 128'h0f0b07030e0a06020d0905010c080400;
    localparam logic [127:0] A1     = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] A2     = 128'hdeadbeef_cafef00d_13579bdf_2468ace0;

    snowv_fsm_update dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .r1_i         (r1_i),
        .r2_i         (r2_i),
        .r3_i         (r3_i),
        .start        (start),
        .t1           (t1),
        .t2           (t2),
        .aes1_start   (aes1_start),
        .aes2_start   (aes2_start),
        .aes1_block_i (aes1_block_i),
        .aes2_block_i (aes2_block_i),
        .aes1_block_o (aes1_block_o),
        .aes2_block_o (aes2_block_o),
        .aes1_ready   (aes1_ready),
        .aes2_ready   (aes2_ready),
        .z            (z),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES unit stand-ins: ready drops after start, returns 3+ex cycles later.
    assign aes1_block_o = aes1_val;
    assign aes2_block_o = aes2_val;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1 <= 0;
            aes1_ready <= 1'b1;
        end else if (aes1_start) begin
            c1 <= 3 + ex1;
            aes1_ready <= 1'b0;
        end else if (c1 != 0) begin
            c1 <= c1 - 1;
            if (c1 == 1) aes1_ready <= 1'b1;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c2 <= 0;
            aes2_ready <= 1'b1;
        end else if (aes2_start) begin
            c2 <= 3 + ex2;
            aes2_ready <= 1'b0;
        end else if (c2 != 0) begin
            c2 <= c2 - 1;
            if (c2 == 1) aes2_ready <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] a, input logic [127:0] b, input logic [127:0] c);
        load = 1'b1;
        r1_i = a;
        r2_i = b;
        r3_i = c;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        chk1({tag, ".done"}, ready, 1'b1);
    endtask

    task automatic do_update(input logic [127:0] t2v, input logic [127:0] a1,
                             input logic [127:0] a2, input string tag);
        aes1_val = a1;
        aes2_val = a2;
        t2       = t2v;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        r1_i     = '0;
        r2_i     = '0;
        r3_i     = '0;
        t1       = {4{32'h11112222}};
        t2       = '0;
        aes1_val = '0;
        aes2_val = '0;
        ex1      = 0;
        ex2      = 0;
        #12;
        chk1("rst.ready", ready, 1'b1);
        chk1("rst.aes1_start", aes1_start, 1'b0);
        chk1("rst.aes2_start", aes2_start, 1'b0);
        chk("rst.blk1", aes1_block_i, '0);
        chk("rst.blk2", aes2_block_i, '0);
`ifdef SNOWV_FSM_ZREG_EN
        chk("rst.z", z, '0);
`else
        chk("rst.z", z, {4{32'h11112222}});
`endif
        reset_n = 1'b1;
        tick();

        // All-zero update: AES(0) with zero key is 0x63 in every byte.
        t1 = '0;
        do_load('0, '0, '0);
        aes1_val = ALL63;
        aes2_val = ALL63;
        t2       = '0;
        start    = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
            chk1($sformatf("t0.ready.c%0d", c), ready, (c == 6));
            chk1($sformatf("t0.start.c%0d", c), aes1_start, (c == 1));
        end
        chk("t0.r1", aes1_block_i, '0);
        chk("t0.r2", aes2_block_i, ALL63);
        tick();
        chk("t0.z", z, ALL63);
        // R2 + R3 = 0x63+0x63 per byte proves R3 was committed.
        do_update('0, '0, '0, "t0b");
        chk("t0b.r1", aes1_block_i, ALLC6);

        // Lane carry: FFFFFFFF + 1 wraps inside each lane.
        do_load({4{32'h12345678}}, {4{32'hFFFFFFFF}}, '0);
        do_update({4{32'h00000001}}, A1, A2, "carry");
        chk("carry.r1", aes1_block_i, '0);
        chk("carry.r2", aes2_block_i, A1);

        do_load('0, SEQ, '0);
        do_update('0, A2, A1, "sigma");
        chk("sigma.r1", aes1_block_i, SIGSEQ);
        chk("sigma.r2", aes2_block_i, A2);

        do_load({4{32'hFFFFFFFF}}, '0, '0);
        t1 = {4{32'h00000002}};
        tick();
        chk("zlane.a", z, {4{32'h00000001}});
        do_load({4{32'h00000001}}, {4{32'hF0F0F0F0}}, '0);
        t1 = {4{32'h00000001}};
        tick();
        chk("zlane.b", z, {4{32'hF0F0F0F2}});

        // Same-cycle load and start: load wins, start dropped.
        load  = 1'b1;
        start = 1'b1;
        r1_i  = A1;
        r2_i  = A2;
        r3_i  = '0;
        tick();
        load  = 1'b0;
        start = 1'b0;
        chk1("ls.ready", ready, 1'b1);
        chk1("ls.aes_start", aes1_start, 1'b0);
        chk("ls.r1", aes1_block_i, A1);
        tick();
        chk1("ls.ready2", ready, 1'b1);

        // load/start during WAIT are ignored; t2 change after start is not seen.
        do_load('0, SEQ, '0);
        aes1_val = A1;
        aes2_val = A2;
        t2       = '0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load  = 1'b1;
        start = 1'b1;
        r1_i  = '1;
        r2_i  = '1;
        t2    = '1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        chk("busy.r1hold", aes1_block_i, '0);
        chk1("busy.ready", ready, 1'b0);
        wait_ready("busy");
        chk("busy.r1", aes1_block_i, SIGSEQ);
        chk("busy.r2", aes2_block_i, A1);
        tick();
        chk1("busy.noissue", aes1_start, 1'b0);

        // AES unit 2 ten cycles slower: commit must wait for both readies.
        do_load('0, SEQ, '0);
        ex2      = 10;
        aes1_val = A2;
        aes2_val = A1;
        t2       = '0;
        start    = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            chk1($sformatf("slow.ready.c%0d", c), ready, (c == 16));
        end
        chk("slow.r1", aes1_block_i, SIGSEQ);
        chk("slow.r2", aes2_block_i, A2);
        ex2 = 0;

        // Reset mid-update aborts without any commit.
        do_load(A1, A2, A1);
        aes1_val = ALL63;
        aes2_val = ALL63;
        t1       = {4{32'h0000abcd}};
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #2;
        chk1("mrst.ready", ready, 1'b1);
        chk("mrst.blk1", aes1_block_i, '0);
        chk("mrst.blk2", aes2_block_i, '0);
        chk1("mrst.aes_start", aes1_start, 1'b0);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk1("mrst.ready2", ready, 1'b1);
        chk("mrst.blk1b", aes1_block_i, '0);
        chk("mrst.z", z, {4{32'h0000abcd}});
        do_update('0, A1, A2, "post");
        chk("post.r1", aes1_block_i, '0);
        chk("post.r2", aes2_block_i, A1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
